// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester and FIFO-side signals of the arbiter; master = requesters/FIFO, slave = arbiter.
interface fifo_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  import fifo_arb_pkg::*;

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_write_en;
  logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_data_in;
  logic                          fifo_full;
  logic                          grant_valid;
  logic [ID_WIDTH-1:0]           grant_id;
  logic                          pkt_done;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id, pkt_done
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id, pkt_done
  );

endinterface

// File: rtl/fifo_rr_arbiter_rr_priority_pick.sv
// Combinational rotating-priority encoder: first set req bit at or above ptr, wrapping at N.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  int          sum;
  logic [W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum  = int'(ptr) + k;
      cand = (sum >= N) ? W'(sum - N) : W'(sum);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between packet requesters; beats tagged with source id.
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters from rr_ptr
//   LOCK  | grant_id owns the FIFO until its last beat is accepted
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              clr,
  fifo_rr_arbiter_if.slave bus
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  arb_state_t          state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_valid;
  logic                pkt_done;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_found;
  logic                sel_valid;
  logic                sel_last;
  logic                xfer;
  logic [DATA_WIDTH-1:0] payload [NUM_REQ];

  rr_priority_pick #(
    .N (NUM_REQ),
    .W (ID_WIDTH)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      payload[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid        = bus.req_valid[grant_id];
  assign sel_last         = bus.req_last[grant_id];
  assign bus.fifo_data_in = {grant_id, payload[grant_id]};
  assign bus.grant_id     = grant_id;
  assign bus.grant_valid  = grant_valid;
  assign bus.pkt_done     = pkt_done;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= xfer && sel_last;
      if (state == IDLE && pick_found) begin
        grant_id    <= pick_idx;
        grant_valid <= 1'b1;
      end else if (xfer && sel_last) begin
        grant_valid <= 1'b0;
        rr_ptr      <= ID_WIDTH'(next_idx(int'(grant_id), NUM_REQ));
      end
    end
  end

  // ready tracks only fifo_full so a requester with valid low still sees its slot held
  always_comb begin
    state_nxt         = state;
    bus.req_ready     = '0;
    bus.fifo_write_en = 1'b0;
    xfer              = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_nxt = LOCK;
      end
      LOCK: begin
        bus.req_ready[grant_id] = !bus.fifo_full;
        xfer                    = sel_valid && !bus.fifo_full;
        bus.fifo_write_en       = xfer;
        if (xfer && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin arbiter that shares one fifo_interconnect write port between NUM_REQ packet-oriented requesters, for example AXI masters pushing write beats.
- Once granted, a requester owns the FIFO until its last beat is accepted. The grant then rotates.
- Each beat is tagged with the source ID so downstream logic can route responses.
- Sits directly in front of a fifo_interconnect instance whose DATA_WIDTH = DATA_WIDTH + ID_WIDTH.

Parameters:
- NUM_REQ, 4: number of requesters. Legal values are ≥2; powers of two are not required.
- DATA_WIDTH, 32: payload width per beat.
- ID_WIDTH (localparam), $clog2(NUM_REQ): source-tag width.

Ports:
- clk  input  1  clock
- clr  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester final beat of packet
- req_data  input  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-requester beat accepted
- fifo_write_en  output  1  to FIFO write_en
- fifo_data_in  output  DATA_WIDTH+ID_WIDTH  to FIFO data_in, packed as {grant_id, payload}
- fifo_full  input  1  from FIFO full
- grant_valid  output  1  a requester currently owns the FIFO
- grant_id  output  ID_WIDTH  index of the owner; only meaningful when grant_valid=1
- pkt_done  output  1  one-cycle pulse when a last beat is accepted

Behaviour:
- Reset (clr=0, asynchronous, takes effect immediately, including mid-packet):
  - state=IDLE, rr_ptr=0, grant_id=0, grant_valid=0, pkt_done=0.
  - req_ready=0 and fifo_write_en=0, since both are combinational from state.
  - A packet in flight is abandoned. The FIFO shares clr, so it is cleared simultaneously.
- States: IDLE, LOCK.
- IDLE:
  - req_ready=0, fifo_write_en=0.
  - If any req_valid bit is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …).
  - Register that index into grant_id, set grant_valid=1, and go to LOCK on the next edge.
  - Arbitration latency is 1 cycle: a valid raised in cycle N can transfer at the earliest in cycle N+1.
- LOCK, with g = grant_id:
  - req_ready[g] = !fifo_full; all other req_ready bits = 0.
  - fifo_write_en = req_valid[g] && !fifo_full.
  - fifo_data_in = {g, req_data[g]}.
  - A beat transfers when req_valid[g] && !fifo_full.
  - If the transferred beat has req_last[g]=1:
    - next state IDLE; grant_valid→0;
    - rr_ptr → (g+1) wrapping at NUM_REQ, i.e. (g==NUM_REQ-1) ? 0 : g+1;
    - pkt_done=1 for that one following cycle.
- Held-grant rules:
  - Requester g dropping req_valid mid-packet keeps the grant; no other requester is served.
  - fifo_full=1 stalls the transfer; the grant is held and data must be held stable by the requester.
  - Requests from other indices arriving during LOCK wait; they are not lost, because requesters hold valid.
- Packet boundaries:
  - There is exactly one IDLE bubble cycle between consecutive packets, even if requests are pending.
  - A single-beat packet (valid and last together) is legal: IDLE→LOCK→IDLE.
- Contract:
  - fifo_write_en is never asserted while fifo_full=1, so the FIFO never sees a dropped write.
  - At most one req_ready bit is high in any cycle.
- Fairness: every continuously requesting index is granted within NUM_REQ packets.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding (IDLE=1'b0, LOCK=1'b1);
  - helper function next_idx(idx, n) for wrap increment.
- One natural sub-module: rr_priority_pick. This is a combinational rotating-priority encoder taking a req vector and ptr, returning idx and found. It is reusable by the future read-channel arbiter.

Test Plan:
1. Reset: hold clr=0 with all req_valid=1 → req_ready=0, fifo_write_en=0, grant_valid=0, rr_ptr=0. Release clr → grant_id=0 one cycle later.
2. Rotation: all 4 requesters each send a 2-beat packet (data 0xA0+i, 0xB0+i), fifo_full=0.
   - FIFO receives {0,0xA0},{0,0xB0},{1,0xA1},{1,0xB1},…,{3,0xB3}.
   - One bubble between packets; pkt_done pulses 4 times.
3. Backpressure: fifo_full=1 for 3 cycles mid-packet of requester 2.
   - fifo_write_en=0 and req_ready[2]=0 during the stall; grant_id stays 2.
   - The beat is written on the first cycle with full=0; no beat is duplicated or lost.
4. Valid gap: requester 1 deasserts valid for 2 cycles mid-packet while requester 3 requests → grant stays 1 until 1's last beat; requester 3 is served next.
5. Wrap and skip: rr_ptr=3 after packets, only req_valid[1] set → grant_id=1. Next arbitration has rr_ptr=2; with requesters 0 and 3 pending, grant_id=3 before 0.
6. Reset mid-packet: assert clr=0 during beat 2 of a 4-beat packet → grant_valid and fifo_write_en drop immediately. After release, arbitration restarts from index 0.
